// File: rtl/zap_wb_arb_pkg.sv
// zap_wb_arb_pkg: shared types and Wishbone CTI codes for the round-robin arbiter
package zap_wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
endpackage

// File: rtl/zap_rr_pick.sv
// zap_rr_pick: rotate-priority encoder, first requester after last_ptr wins
module zap_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last_ptr,
  output logic [N-1:0]  win,
  output logic          valid
);
  logic [PW-1:0] idx;
  // scan from farthest to nearest so the nearest requester overwrites last
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      idx = PW'((int'(last_ptr) + i) % N);
      if (req[idx]) win = N'(1) << idx;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/zap_wb_rr_arbiter.sv
// zap_wb_rr_arbiter: burst-aware round-robin Wishbone arbiter with ack watchdog
module zap_wb_rr_arbiter
  import zap_wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_MASTERS-1:0]    i_m_wb_cyc,
  input  logic [NUM_MASTERS-1:0]    i_m_wb_stb,
  input  logic [NUM_MASTERS-1:0]    i_m_wb_wen,
  input  logic [4*NUM_MASTERS-1:0]  i_m_wb_sel,
  input  logic [32*NUM_MASTERS-1:0] i_m_wb_dat,
  input  logic [32*NUM_MASTERS-1:0] i_m_wb_adr,
  input  logic [3*NUM_MASTERS-1:0]  i_m_wb_cti,
  output logic [NUM_MASTERS-1:0]    o_m_wb_ack,
  output logic [31:0]               o_m_wb_dat,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_wen,
  output logic [3:0]                o_wb_sel,
  output logic [31:0]               o_wb_dat,
  output logic [31:0]               o_wb_adr,
  output logic [2:0]                o_wb_cti,
  input  logic                      i_wb_ack,
  input  logic [31:0]               i_wb_dat,
  output logic [NUM_MASTERS-1:0]    o_grant,
  output logic                      o_timeout
);
  localparam int N  = NUM_MASTERS;
  localparam int PW = $clog2(N);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t        state, state_n;
  logic [N-1:0]  grant, grant_n, win;
  logic [PW-1:0] last_ptr, ptr_n, widx;
  logic [CW-1:0] cnt, cnt_n;
  logic          valid, tmo_n, done, dropped, expired;
  zap_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req(i_m_wb_cyc & i_m_wb_stb), .last_ptr(last_ptr), .win(win), .valid(valid)
  );
  always_comb begin
    widx = '0;
    for (int k = 0; k < N; k++) if (win[k]) widx = PW'(k);
  end
  // grant is zero outside BUSY, so the AND-OR mux idles the bus by itself
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_wen = 1'b0;
    o_wb_sel = '0;
    o_wb_dat = '0;
    o_wb_adr = '0;
    o_wb_cti = '0;
    for (int k = 0; k < N; k++) begin
      o_wb_cyc = o_wb_cyc | (grant[k] & i_m_wb_cyc[k]);
      o_wb_stb = o_wb_stb | (grant[k] & i_m_wb_stb[k]);
      o_wb_wen = o_wb_wen | (grant[k] & i_m_wb_wen[k]);
      o_wb_sel = o_wb_sel | ({4{grant[k]}} & i_m_wb_sel[4*k+:4]);
      o_wb_dat = o_wb_dat | ({32{grant[k]}} & i_m_wb_dat[32*k+:32]);
      o_wb_adr = o_wb_adr | ({32{grant[k]}} & i_m_wb_adr[32*k+:32]);
      o_wb_cti = o_wb_cti | ({3{grant[k]}} & i_m_wb_cti[3*k+:3]);
    end
  end
  assign o_grant    = grant;
  assign o_m_wb_ack = grant & {N{i_wb_ack}};
  assign o_m_wb_dat = i_wb_dat;
  assign done    = i_wb_ack && (o_wb_cti == CTI_CLASSIC || o_wb_cti == CTI_EOB);
  assign dropped = !(|(grant & i_m_wb_cyc));
  assign expired = (TIMEOUT_CYCLES != 0) && !i_wb_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = last_ptr;
    cnt_n   = cnt;
    tmo_n   = 1'b0;
    if (state == IDLE) begin
      if (valid) begin
        state_n = BUSY;
        grant_n = win;
        ptr_n   = widx;
        cnt_n   = '0;
      end
    end else if (state == BUSY) begin
      cnt_n = i_wb_ack ? '0 : cnt + CW'(1);
      if (done || dropped || expired) begin
        state_n = GAP;
        grant_n = '0;
        tmo_n   = !done && !dropped;
      end
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      grant     <= '0;
      last_ptr  <= PW'(N - 1);
      cnt       <= '0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      last_ptr  <= ptr_n;
      cnt       <= cnt_n;
      o_timeout <= tmo_n;
    end
  end
endmodule

// File: tb/tb_zap_wb_rr_arbiter.sv
// tb_zap_wb_rr_arbiter: cycle-vector checks of grant order, bursts, watchdog and reset
module tb_zap_wb_rr_arbiter;
  logic         i_clk = 1'b0;
  logic         i_reset;
  logic [3:0]   i_m_wb_cyc, i_m_wb_stb, i_m_wb_wen;
  logic [15:0]  i_m_wb_sel;
  logic [127:0] i_m_wb_dat, i_m_wb_adr;
  logic [11:0]  i_m_wb_cti;
  logic [3:0]   o_m_wb_ack, o_grant;
  logic [31:0]  o_m_wb_dat, o_wb_dat, o_wb_adr, i_wb_dat;
  logic         o_wb_cyc, o_wb_stb, o_wb_wen, i_wb_ack, o_timeout;
  logic [3:0]   o_wb_sel;
  logic [2:0]   o_wb_cti;
  int total = 0, passed = 0;

  typedef struct {
    logic [3:0] cyc;
    logic [2:0] cti;
    logic       ack;
    logic [3:0] eg;
    logic [3:0] eack;
    logic       ecyc;
    logic       etmo;
  } row_t;
  row_t tbl[$];

  zap_wb_rr_arbiter #(.NUM_MASTERS(4), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m_wb_cyc(i_m_wb_cyc), .i_m_wb_stb(i_m_wb_stb), .i_m_wb_wen(i_m_wb_wen),
    .i_m_wb_sel(i_m_wb_sel), .i_m_wb_dat(i_m_wb_dat), .i_m_wb_adr(i_m_wb_adr),
    .i_m_wb_cti(i_m_wb_cti), .o_m_wb_ack(o_m_wb_ack), .o_m_wb_dat(o_m_wb_dat),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen), .o_wb_sel(o_wb_sel),
    .o_wb_dat(o_wb_dat), .o_wb_adr(o_wb_adr), .o_wb_cti(o_wb_cti),
    .i_wb_ack(i_wb_ack), .i_wb_dat(i_wb_dat), .o_grant(o_grant), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic add(input logic [3:0] c, input logic [2:0] t, input logic a,
                     input logic [3:0] g, input logic [3:0] k, input logic y, input logic o);
    tbl.push_back('{c, t, a, g, k, y, o});
  endtask

  // drive one cycle on the falling edge, then compare every output against the expected grant
  task automatic step(input logic [3:0] cyc, input logic [2:0] cti, input logic ack,
                      input logic [3:0] eg, input logic [3:0] eack, input logic ecyc,
                      input logic etmo, input string nm);
    logic [114:0] act, exp;
    logic [31:0]  eadr, edat, rd;
    logic         ewen;
    @(negedge i_clk);
    rd = 32'hC0DE_0000 | 32'(total);
    i_m_wb_cyc = cyc;
    i_m_wb_stb = cyc;
    i_m_wb_cti = {4{cti}};
    i_wb_ack   = ack;
    i_wb_dat   = rd;
    #1;
    eadr = '0;
    edat = '0;
    for (int k = 0; k < 4; k++)
      if (eg[k]) begin
        eadr = 32'hA000_0000 | 32'(k << 4);
        edat = 32'hD000_0000 + 32'(k);
      end
    ewen = |(eg & 4'b1010);
    exp = {eg, eack, ecyc, ecyc, etmo, ewen, eg, (eg != 4'b0) ? cti : 3'b000, eadr, edat, rd};
    act = {o_grant, o_m_wb_ack, o_wb_cyc, o_wb_stb, o_timeout, o_wb_wen, o_wb_sel, o_wb_cti,
           o_wb_adr, o_wb_dat, o_m_wb_dat};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    i_reset = 1'b1;
    i_m_wb_cyc = '0; i_m_wb_stb = '0; i_m_wb_cti = '0; i_wb_ack = 1'b0; i_wb_dat = '0;
    i_m_wb_wen = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      i_m_wb_adr[32*k+:32] = 32'hA000_0000 | 32'(k << 4);
      i_m_wb_dat[32*k+:32] = 32'hD000_0000 + 32'(k);
      i_m_wb_sel[4*k+:4]   = 4'(1 << k);
    end
    // all four request classic cycles: 0,1,2,3,0 with GAP+IDLE between grants
    add(4'b1111, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1111, 3'b000, 1, 4'b0001, 4'b0001, 1, 0);
    add(4'b1111, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1111, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1111, 3'b000, 1, 4'b0010, 4'b0010, 1, 0);
    add(4'b1111, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1111, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1111, 3'b000, 1, 4'b0100, 4'b0100, 1, 0);
    add(4'b1111, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1111, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1111, 3'b000, 1, 4'b1000, 4'b1000, 1, 0);
    add(4'b1111, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1111, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1111, 3'b000, 1, 4'b0001, 4'b0001, 1, 0);
    add(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    // master 1 single classic read, ack on its second bus cycle
    add(4'b0010, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0010, 3'b000, 0, 4'b0010, 4'b0000, 1, 0);
    add(4'b0010, 3'b000, 1, 4'b0010, 4'b0010, 1, 0);
    add(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    // master 0 burst 010,010,010,111 with a wait state; master 2 waits
    add(4'b0001, 3'b010, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0101, 3'b010, 1, 4'b0001, 4'b0001, 1, 0);
    add(4'b0101, 3'b010, 0, 4'b0001, 4'b0000, 1, 0);
    add(4'b0101, 3'b010, 1, 4'b0001, 4'b0001, 1, 0);
    add(4'b0101, 3'b010, 1, 4'b0001, 4'b0001, 1, 0);
    add(4'b0101, 3'b111, 1, 4'b0001, 4'b0001, 1, 0);
    add(4'b0100, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0100, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0100, 3'b000, 1, 4'b0100, 4'b0100, 1, 0);
    add(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    // master 3 drops cyc mid-burst: released with no ack
    add(4'b1000, 3'b010, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b1000, 3'b010, 1, 4'b1000, 4'b1000, 1, 0);
    add(4'b0000, 3'b010, 0, 4'b1000, 4'b0000, 0, 0);
    add(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);
    add(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0);

    repeat (2) @(posedge i_clk);
    step(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0, "reset_state");
    i_reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].cyc, tbl[i].cti, tbl[i].ack, tbl[i].eg, tbl[i].eack, tbl[i].ecyc,
           tbl[i].etmo, $sformatf("tbl%0d", i));

    // watchdog: master 0 never acked, pulse after 8 bus cycles, then master 1 served
    step(4'b0011, 3'b000, 0, 4'b0000, 4'b0000, 0, 0, "wd_idle");
    for (int i = 0; i < 8; i++)
      step(4'b0011, 3'b000, 0, 4'b0001, 4'b0000, 1, 0, "wd_busy");
    step(4'b0011, 3'b000, 0, 4'b0000, 4'b0000, 0, 1, "wd_pulse");
    step(4'b0011, 3'b000, 0, 4'b0000, 4'b0000, 0, 0, "wd_pulse_end");
    step(4'b0011, 3'b000, 1, 4'b0010, 4'b0010, 1, 0, "wd_next_grant");
    step(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0, "wd_gap");
    step(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0, "wd_idle2");

    // acks landing exactly on the expiry cycle win over the watchdog
    step(4'b0100, 3'b010, 0, 4'b0000, 4'b0000, 0, 0, "exp_idle");
    for (int i = 0; i < 7; i++)
      step(4'b0100, 3'b010, 0, 4'b0100, 4'b0000, 1, 0, "exp_wait");
    step(4'b0100, 3'b010, 1, 4'b0100, 4'b0100, 1, 0, "ack_at_expiry");
    for (int i = 0; i < 7; i++)
      step(4'b0100, 3'b010, 0, 4'b0100, 4'b0000, 1, 0, "after_clear");
    step(4'b0100, 3'b111, 1, 4'b0100, 4'b0100, 1, 0, "eob_at_expiry");
    step(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0, "exp_no_tmo");
    step(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0, "exp_idle2");

    // reset in the middle of a burst, then master 0 wins first
    step(4'b1000, 3'b010, 0, 4'b0000, 4'b0000, 0, 0, "rst_idle");
    step(4'b1000, 3'b010, 1, 4'b1000, 4'b1000, 1, 0, "rst_burst");
    i_reset = 1'b1;
    step(4'b1111, 3'b000, 0, 4'b0000, 4'b0000, 0, 0, "rst_mid_burst");
    i_reset = 1'b0;
    step(4'b1111, 3'b000, 1, 4'b0001, 4'b0001, 1, 0, "post_rst_m0");
    step(4'b0000, 3'b000, 0, 4'b0000, 4'b0000, 0, 0, "post_rst_gap");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
